// File: rtl/bridge_pkg.sv
// bridge_pkg: opcodes and FSM state encoding shared by the UART bus bridge
package bridge_pkg;
  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] OP_READ  = 8'h52;
  localparam logic [7:0] ACK_BYTE = 8'h2E;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GET_ADDR,
    ST_GET_DATA,
    ST_BUS_WAIT,
    ST_BUS_CYCLE,
    ST_TX_START,
    ST_TX_WAIT
  } state_e;
endpackage

// File: rtl/uart_bus_bridge_rx_accept.sv
// uart_bus_bridge_rx_accept: one-shot rx byte handshake, re-armed only after rx_ready drops
module uart_bus_bridge_rx_accept (
  input  logic       raw_clk,
  input  logic       reset,
  input  logic [7:0] rx_data_i,
  input  logic       rx_ready_i,
  input  logic       take_i,
  output logic       rx_ready_clear_o,
  output logic       byte_valid_o,
  output logic [7:0] byte_o
);
  logic       armed_q;
  logic       clear_q;
  logic [7:0] byte_q;
  logic       accept;
  assign accept           = rx_ready_i & armed_q & take_i;
  assign rx_ready_clear_o = clear_q;
  assign byte_valid_o     = clear_q;
  assign byte_o           = byte_q;
  // capture an accepted byte, pulse clear once, and disarm until rx_ready is seen low
  always_ff @(posedge raw_clk) begin
    if (reset) begin
      armed_q <= 1'b0;
      clear_q <= 1'b0;
      byte_q  <= 8'h00;
    end else begin
      armed_q <= accept ? 1'b0 : (armed_q | ~rx_ready_i);
      clear_q <= accept;
      if (accept) byte_q <= rx_data_i;
    end
  end
endmodule

// File: rtl/uart_bus_bridge.sv
// uart_bus_bridge: UART-driven debug master for the 6-bit register bus; UART_BUS_BRIDGE_ACK_EN adds '.' write acks
module uart_bus_bridge
  import bridge_pkg::*;
#(
  parameter int READ_LATENCY   = 2,
  parameter int TIMEOUT_CYCLES = 2700000
) (
  input  logic       raw_clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_ready,
  output logic       rx_ready_clear,
  output logic [7:0] tx_data,
  output logic       tx_strobe,
  input  logic       tx_busy,
  output logic       bus_enable,
  output logic [5:0] bus_address,
  output logic [7:0] bus_data_out,
  output logic       bus_write_enable,
  input  logic [7:0] bus_data_in,
  input  logic       wait_video,
  output logic       busy
);
  state_e      state_q, state_d;
  logic        wr_q, wr_d;
  logic [5:0]  addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  txd_q, txd_d;
  logic [31:0] to_q, to_d;
  logic [7:0]  lat_q, lat_d;
  logic        byte_valid;
  logic [7:0]  rx_byte;
  logic        in_get;
  logic        timeout_hit;
  logic        take;
  assign in_get      = (state_q == ST_GET_ADDR) || (state_q == ST_GET_DATA);
  assign timeout_hit = in_get && (to_q == 32'(TIMEOUT_CYCLES - 1));
  assign take        = (state_q == ST_IDLE) || (in_get && !timeout_hit);
  uart_bus_bridge_rx_accept u_rx (
    .raw_clk          (raw_clk),
    .reset            (reset),
    .rx_data_i        (rx_data),
    .rx_ready_i       (rx_ready),
    .take_i           (take),
    .rx_ready_clear_o (rx_ready_clear),
    .byte_valid_o     (byte_valid),
    .byte_o           (rx_byte)
  );
  assign busy             = state_q != ST_IDLE;
  assign bus_enable       = state_q == ST_BUS_CYCLE;
  assign bus_write_enable = bus_enable & wr_q;
  assign bus_address      = addr_q;
  assign bus_data_out     = wdata_q;
  assign tx_data          = txd_q;
  assign tx_strobe        = state_q == ST_TX_START;
  // command sequencing: collect bytes, run the bus cycle, then send the reply
  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    txd_d   = txd_q;
    to_d    = 32'd0;
    lat_d   = 8'd0;
    case (state_q)
      ST_IDLE: if (byte_valid && (rx_byte == OP_WRITE || rx_byte == OP_READ)) begin
        wr_d    = rx_byte == OP_WRITE;
        state_d = ST_GET_ADDR;
      end
      ST_GET_ADDR: if (byte_valid) begin
        addr_d  = rx_byte[5:0];
        state_d = wr_q ? ST_GET_DATA : ST_BUS_WAIT;
      end else if (timeout_hit) state_d = ST_IDLE;
      else to_d = to_q + 32'd1;
      ST_GET_DATA: if (byte_valid) begin
        wdata_d = rx_byte;
        state_d = ST_BUS_WAIT;
      end else if (timeout_hit) state_d = ST_IDLE;
      else to_d = to_q + 32'd1;
      ST_BUS_WAIT: state_d = wait_video ? ST_BUS_WAIT : ST_BUS_CYCLE;
      ST_BUS_CYCLE: if (wr_q) begin
`ifdef UART_BUS_BRIDGE_ACK_EN
        txd_d   = ACK_BYTE;
        state_d = ST_TX_START;
`else
        state_d = ST_IDLE;
`endif
      end else if (lat_q == 8'(READ_LATENCY - 1)) begin
        txd_d   = bus_data_in;
        state_d = ST_TX_START;
      end else lat_d = lat_q + 8'd1;
      ST_TX_START: state_d = tx_busy ? ST_TX_WAIT : ST_TX_START;
      ST_TX_WAIT:  state_d = tx_busy ? ST_TX_WAIT : ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end
  // state registers; reset abandons any command in flight
  always_ff @(posedge raw_clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      wr_q    <= 1'b0;
      addr_q  <= 6'd0;
      wdata_q <= 8'h00;
      txd_q   <= 8'h00;
      to_q    <= 32'd0;
      lat_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      txd_q   <= txd_d;
      to_q    <= to_d;
      lat_q   <= lat_d;
    end
  end
endmodule

// File: tb/tb_uart_bus_bridge.sv
// tb_uart_bus_bridge: vector table, corner sequences and random commands against a register-map model
module tb_uart_bus_bridge;
  localparam int TO = 100;
`ifdef UART_BUS_BRIDGE_ACK_EN
  localparam int ACK = 1;
`else
  localparam int ACK = 0;
`endif
  localparam logic [7:0] W = 8'h57;
  localparam logic [7:0] R = 8'h52;
  logic       raw_clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_ready = 1'b0;
  logic       rx_ready_clear;
  logic [7:0] tx_data;
  logic       tx_strobe;
  logic       tx_busy = 1'b0;
  logic       bus_enable;
  logic [5:0] bus_address;
  logic [7:0] bus_data_out;
  logic       bus_write_enable;
  logic [7:0] bus_data_in;
  logic       wait_video = 1'b0;
  logic       busy;
  always #5 raw_clk = ~raw_clk;
  uart_bus_bridge #(.READ_LATENCY(2), .TIMEOUT_CYCLES(TO)) dut (
    .raw_clk(raw_clk), .reset(reset), .rx_data(rx_data), .rx_ready(rx_ready),
    .rx_ready_clear(rx_ready_clear), .tx_data(tx_data), .tx_strobe(tx_strobe),
    .tx_busy(tx_busy), .bus_enable(bus_enable), .bus_address(bus_address),
    .bus_data_out(bus_data_out), .bus_write_enable(bus_write_enable),
    .bus_data_in(bus_data_in), .wait_video(wait_video), .busy(busy)
  );
  int total = 0;
  int bad = 0;
  int n_en = 0, n_we = 0, n_tx = 0, n_clr = 0;
  int tx_delay = 1;
  logic [5:0] waddr = 6'd0, raddr = 6'd0;
  logic [7:0] wdata = 8'h00, last_tx = 8'h00;
  logic [7:0] periph [64];
  logic [7:0] model [64];
  typedef struct {
    logic [7:0] op, addr, data;
    int en, we, tx;
    logic [7:0] rbyte;
  } vec_t;
  vec_t tbl [6];
  function automatic logic [7:0] pinit(input int i);
    return (i == 19) ? 8'h5C : 8'(i * 5 + 3);
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  always @(posedge raw_clk) begin
    if (reset) begin
      for (int i = 0; i < 64; i++) periph[i] <= pinit(i);
      bus_data_in <= 8'h00;
    end else begin
      bus_data_in <= bus_enable ? periph[bus_address] : 8'h00;
      if (bus_enable && bus_write_enable) periph[bus_address] <= bus_data_out;
    end
  end
  always @(negedge raw_clk) begin
    if (!reset) begin
      if (bus_enable) begin
        n_en++;
        if (bus_write_enable) begin
          n_we++;
          waddr = bus_address;
          wdata = bus_data_out;
        end else raddr = bus_address;
      end
      if (rx_ready_clear) n_clr++;
    end
  end
  initial begin
    forever begin
      @(negedge raw_clk);
      if (tx_strobe && !tx_busy) begin
        n_tx++;
        last_tx = tx_data;
        repeat (tx_delay) @(negedge raw_clk);
        chk("tx_strobe_held", {31'd0, tx_strobe}, 1);
        tx_busy = 1'b1;
        repeat (4) @(negedge raw_clk);
        tx_busy = 1'b0;
      end
    end
  end
  task automatic send_byte(input logic [7:0] b);
    @(negedge raw_clk);
    rx_data  = b;
    rx_ready = 1'b1;
    for (int k = 0; k < 100 && !rx_ready_clear; k++) @(negedge raw_clk);
    chk("rx_accept", {31'd0, rx_ready_clear}, 1);
    rx_ready = 1'b0;
  endtask
  task automatic wait_idle();
    for (int k = 0; k < 2000 && busy; k++) @(negedge raw_clk);
    chk("idle", {31'd0, busy}, 0);
  endtask
  task automatic run_cmd(input logic [7:0] op, input logic [7:0] addr, input logic [7:0] data,
                         input int exp_en, input int exp_we, input int exp_tx, input logic [7:0] exp_byte);
    int en0, we0, tx0;
    en0 = n_en;
    we0 = n_we;
    tx0 = n_tx;
    send_byte(op);
    send_byte(addr);
    if (op == W) send_byte(data);
    wait_idle();
    repeat (2) @(negedge raw_clk);
    chk("en_cycles", n_en - en0, exp_en);
    chk("we_cycles", n_we - we0, exp_we);
    chk("tx_count", n_tx - tx0, exp_tx);
    if (exp_tx > 0) chk("tx_byte", last_tx, exp_byte);
    if (exp_we > 0) begin
      chk("waddr", waddr, addr[5:0]);
      chk("wdata", wdata, data);
    end
    if (exp_en > 0 && exp_we == 0) chk("raddr", raddr, addr[5:0]);
  endtask
  initial begin
    int en0, tx0, c0;
    logic [7:0] op, a, d;
    for (int i = 0; i < 64; i++) model[i] = pinit(i);
    tbl[0] = '{W, 8'h08, 8'hA4, 1, 1, ACK, 8'h2E};
    tbl[1] = '{R, 8'h13, 8'h00, 2, 0, 1, 8'h5C};
    tbl[2] = '{R, 8'h48, 8'h00, 2, 0, 1, 8'hA4};
    tbl[3] = '{W, 8'hC0, 8'hFF, 1, 1, ACK, 8'h2E};
    tbl[4] = '{R, 8'h00, 8'h00, 2, 0, 1, 8'hFF};
    tbl[5] = '{R, 8'h3F, 8'h00, 2, 0, 1, 8'h3E};
    repeat (3) @(negedge raw_clk);
    chk("reset_outs", {busy, bus_enable, bus_write_enable, tx_strobe, rx_ready_clear, bus_address, bus_data_out, tx_data}, 0);
    reset = 1'b0;
    repeat (2) @(negedge raw_clk);
    for (int i = 0; i < 6; i++) begin
      run_cmd(tbl[i].op, tbl[i].addr, tbl[i].data, tbl[i].en, tbl[i].we, tbl[i].tx, tbl[i].rbyte);
      if (tbl[i].op == W) model[tbl[i].addr[5:0]] = tbl[i].data;
    end
    c0 = n_clr;
    en0 = n_en;
    @(negedge raw_clk);
    rx_data  = R;
    rx_ready = 1'b1;
    repeat (10) @(negedge raw_clk);
    rx_ready = 1'b0;
    chk("hold_clr_pulses", n_clr - c0, 1);
    chk("hold_busy", {31'd0, busy}, 1);
    send_byte(8'h13);
    wait_idle();
    repeat (2) @(negedge raw_clk);
    chk("hold_en", n_en - en0, 2);
    chk("hold_raddr", raddr, 6'h13);
    chk("hold_reply", last_tx, model[19]);
    en0 = n_en;
    wait_video = 1'b1;
    send_byte(W);
    send_byte(8'h11);
    send_byte(8'h77);
    repeat (50) @(negedge raw_clk);
    chk("wv_no_enable", n_en - en0, 0);
    chk("wv_busy", {31'd0, busy}, 1);
    wait_video = 1'b0;
    @(negedge raw_clk);
    chk("wv_enable_next", {31'd0, bus_enable}, 1);
    wait_idle();
    repeat (2) @(negedge raw_clk);
    chk("wv_en_count", n_en - en0, 1);
    chk("wv_data", {waddr, wdata}, {6'h11, 8'h77});
    model[17] = 8'h77;
    en0 = n_en;
    send_byte(W);
    send_byte(8'h02);
    repeat (90) @(negedge raw_clk);
    chk("to_still_busy", {31'd0, busy}, 1);
    for (int k = 0; k < 40 && busy; k++) @(negedge raw_clk);
    chk("to_aborted", {31'd0, busy}, 0);
    chk("to_no_bus", n_en - en0, 0);
    run_cmd(R, 8'h01, 8'h00, 2, 0, 1, model[1]);
    c0 = n_clr;
    send_byte(8'hFF);
    for (int k = 0; k < 3; k++) begin
      @(negedge raw_clk);
      chk("junk_idle", {31'd0, busy}, 0);
    end
    chk("junk_consumed", n_clr - c0, 1);
    en0 = n_en;
    tx0 = n_tx;
    send_byte(W);
    send_byte(8'h05);
    @(negedge raw_clk);
    reset = 1'b1;
    @(negedge raw_clk);
    chk("midreset_outs", {busy, bus_enable, bus_write_enable, tx_strobe, rx_ready_clear, bus_address, bus_data_out, tx_data}, 0);
    @(negedge raw_clk);
    reset = 1'b0;
    for (int i = 0; i < 64; i++) model[i] = pinit(i);
    repeat (20) @(negedge raw_clk);
    chk("midreset_no_bus", n_en - en0, 0);
    chk("midreset_no_tx", n_tx - tx0, 0);
    run_cmd(W, 8'h05, 8'h33, 1, 1, ACK, 8'h2E);
    model[5] = 8'h33;
    run_cmd(R, 8'h05, 8'h00, 2, 0, 1, model[5]);
    for (int i = 0; i < 40; i++) begin
      op = ($urandom_range(0, 1) == 1) ? W : R;
      a = 8'($urandom);
      d = 8'($urandom);
      tx_delay = $urandom_range(0, 3);
      if (op == W) begin
        run_cmd(op, a, d, 1, 1, ACK, 8'h2E);
        model[a[5:0]] = d;
      end else run_cmd(op, a, d, 2, 0, 1, model[a[5:0]]);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
